mouse_quad_counter: RTL and testbench



---
 rtl/mouse_quad_counter.sv | 168 ++++++++++++++++
 tb/tb_mouse_quad_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_quad_counter.sv
// Quadrature position counter and button debouncer for the mouse/trackball port.
// Define QUAD_GLITCH_FILTER_EN to add a third sync stage that rejects one-cycle pin pulses.
module mouse_quad_counter #(
    parameter int AXES = 2,
    parameter int CW   = 10,
    parameter int NBTN = 3,
    parameter int DEB  = 4,
    parameter int SAT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AXES-1:0]    qa,
    input  logic [AXES-1:0]    qb,
    input  logic [NBTN-1:0]    btn_n,
    input  logic               clr,
    output logic [AXES*CW-1:0] count,
    output logic [NBTN-1:0]    btn,
    output logic [AXES-1:0]    err,
    output logic [AXES-1:0]    step
);

    logic [AXES-1:0] qa_s1, qa_s2, qb_s1, qb_s2;
`ifdef QUAD_GLITCH_FILTER_EN
    logic [AXES-1:0] qa_s3, qb_s3;
`endif
    logic [NBTN-1:0] btn_s1, btn_s2;
    logic [NBTN-1:0] lvl;

    logic [1:0] arm_cnt;
    logic       armed;

    logic [AXES-1:0][1:0]    p_q;
    logic [AXES-1:0][1:0]    cur;
    logic [AXES-1:0]         cur_ok;
    logic [AXES-1:0]         up;
    logic [AXES-1:0]         dn;
    logic [AXES-1:0]         bad;
    logic [AXES-1:0]         step_d;
    logic [AXES-1:0][CW-1:0] cnt_q;
    logic [AXES-1:0][CW-1:0] cnt_d;

    logic [NBTN-1:0][DEB-1:0] deb_q;

    // Position of an {A,B} state along the up sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    assign armed = (arm_cnt == 2'd3);
    assign count = cnt_q;
    assign lvl   = ~btn_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa_s1  <= '0;
            qa_s2  <= '0;
            qb_s1  <= '0;
            qb_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
`ifdef QUAD_GLITCH_FILTER_EN
            qa_s3  <= '0;
            qb_s3  <= '0;
`endif
        end else begin
            qa_s1  <= qa;
            qa_s2  <= qa_s1;
            qb_s1  <= qb;
            qb_s2  <= qb_s1;
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
`ifdef QUAD_GLITCH_FILTER_EN
            qa_s3  <= qa_s2;
            qb_s3  <= qb_s2;
`endif
        end
    end

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        logic [1:0] delta;
        delta  = 2'd0;
        cur    = '0;
        cur_ok = '0;
        up     = '0;
        dn     = '0;
        bad    = '0;
        step_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < AXES; i++) begin
`ifdef QUAD_GLITCH_FILTER_EN
            cur[i]    = {qa_s3[i], qb_s3[i]};
            cur_ok[i] = (cur[i] == {qa_s2[i], qb_s2[i]});
`else
            cur[i]    = {qa_s2[i], qb_s2[i]};
            cur_ok[i] = 1'b1;
`endif
            delta  = gray_pos(cur[i]) - gray_pos(p_q[i]);
            up[i]  = armed && cur_ok[i] && (delta == 2'd1);
            dn[i]  = armed && cur_ok[i] && (delta == 2'd3);
            bad[i] = armed && cur_ok[i] && (delta == 2'd2);
            if (up[i] && !(SAT != 0 && cnt_q[i] == '1)) begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
                step_d[i] = 1'b1;
            end else if (dn[i] && !(SAT != 0 && cnt_q[i] == '0)) begin
                cnt_d[i]  = cnt_q[i] - 1'b1;
                step_d[i] = 1'b1;
            end
        end
    end

    // While unarmed, p tracks the synchronised pins so a resting mouse decodes as idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt <= 2'd0;
            p_q     <= '0;
            cnt_q   <= '0;
            err     <= '0;
            step    <= '0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            for (int i = 0; i < AXES; i++) begin
                if (!armed) begin
                    p_q[i] <= {qa_s2[i], qb_s2[i]};
                end else if (cur_ok[i]) begin
                    p_q[i] <= cur[i];
                end
            end
            if (clr) begin
                cnt_q <= '0;
                err   <= '0;
                step  <= '0;
            end else begin
                cnt_q <= cnt_d;
                err   <= err | bad;
                step  <= step_d;
            end
        end
    end

    // A button is accepted after its new level has been stable for 2^DEB cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
            btn   <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (lvl[i] == btn[i]) begin
                    deb_q[i] <= '0;
                end else if (&deb_q[i]) begin
                    btn[i]   <= lvl[i];
                    deb_q[i] <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mouse_quad_counter.sv
// Directed bench for mouse_quad_counter: one wrapping and one saturating instance share stimulus.
module tb_mouse_quad_counter;
    localparam int AXES = 2;
    localparam int CW   = 10;
    localparam int NBTN = 3;
    localparam int DEB  = 4;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk   = 1'b0;
    logic               rst   = 1'b0;
    logic               clr   = 1'b0;
    logic [AXES-1:0]    qa    = '1;
    logic [AXES-1:0]    qb    = '1;
    logic [NBTN-1:0]    btn_n = '1;
    logic [AXES*CW-1:0] count, count_s;
    logic [NBTN-1:0]    btn, btn_s;
    logic [AXES-1:0]    err, err_s, step, step_s;

    int total = 0;
    int bad   = 0;
    int steps_w0 = 0, steps_w1 = 0, steps_s0 = 0, steps_s1 = 0;

    mouse_quad_counter #(.AXES(AXES), .CW(CW), .NBTN(NBTN), .DEB(DEB), .SAT(0)) dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .btn_n(btn_n), .clr(clr),
        .count(count), .btn(btn), .err(err), .step(step)
    );

    mouse_quad_counter #(.AXES(AXES), .CW(CW), .NBTN(NBTN), .DEB(DEB), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .btn_n(btn_n), .clr(clr),
        .count(count_s), .btn(btn_s), .err(err_s), .step(step_s)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step[0])   steps_w0++;
        if (step[1])   steps_w1++;
        if (step_s[0]) steps_s0++;
        if (step_s[1]) steps_s1++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ab(input int ax, input logic [1:0] ab);
        qa[ax] = ab[1];
        qb[ax] = ab[0];
    endtask

    task automatic test_reset();
        int snap;
        rst = 1'b0;
        tick(3);
        total++;
        if (count !== '0 || err !== '0 || step !== '0 || btn !== '0) begin
            bad++;
            $display("FAIL reset_state: count=%h err=%b step=%b btn=%b want all zero", count, err, step, btn);
        end
        snap = steps_w0 + steps_w1 + steps_s0 + steps_s1;
        rst = 1'b1;
        tick(20);
        total++;
        if (steps_w0 + steps_w1 + steps_s0 + steps_s1 - snap != 0) begin
            bad++;
            $display("FAIL reset_idle_step: got %0d step pulses want 0", steps_w0 + steps_w1 + steps_s0 + steps_s1 - snap);
        end
        total++;
        if (count !== '0 || err !== '0 || count_s !== '0 || err_s !== '0) begin
            bad++;
            $display("FAIL reset_idle_state: count=%h err=%b count_s=%h err_s=%b want zero", count, err, count_s, err_s);
        end
    endtask

    task automatic test_forward();
        int snap;
        set_ab(0, 2'b01);
        tick(5);
        set_ab(0, 2'b00);
        tick(5);
        total++;
        if (count[CW-1:0] !== 10'd2) begin
            bad++;
            $display("FAIL fwd_setup: got %0d want 2", count[CW-1:0]);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        total++;
        if (count !== '0 || count_s !== '0) begin
            bad++;
            $display("FAIL fwd_clr: count=%h count_s=%h want 0", count, count_s);
        end
        snap = steps_w0;
        set_ab(0, 2'b10);
        tick(LAT - 1);
        total++;
        if (count[CW-1:0] !== 10'd0) begin
            bad++;
            $display("FAIL fwd_early: got %0d want 0 before latency", count[CW-1:0]);
        end
        tick(1);
        total++;
        if (count[CW-1:0] !== 10'd1 || step[0] !== 1'b1) begin
            bad++;
            $display("FAIL fwd_first: count=%0d step=%b want 1 and 1", count[CW-1:0], step[0]);
        end
        tick(1);
        total++;
        if (step[0] !== 1'b0) begin
            bad++;
            $display("FAIL fwd_pulse_width: step=%b want 0", step[0]);
        end
        tick(5 - LAT);
        set_ab(0, 2'b11);
        tick(5);
        set_ab(0, 2'b01);
        tick(5);
        set_ab(0, 2'b00);
        tick(5);
        total++;
        if (count[CW-1:0] !== 10'd4 || count_s[CW-1:0] !== 10'd4) begin
            bad++;
            $display("FAIL fwd_count: got %0d/%0d want 4/4", count[CW-1:0], count_s[CW-1:0]);
        end
        total++;
        if (steps_w0 - snap != 4) begin
            bad++;
            $display("FAIL fwd_steps: got %0d pulses want 4", steps_w0 - snap);
        end
    endtask

    task automatic test_wrap();
        set_ab(1, 2'b10);
        tick(LAT);
        total++;
        if (count[2*CW-1:CW] !== 10'd1023 || step[1] !== 1'b1) begin
            bad++;
            $display("FAIL wrap_down: count=%0d step=%b want 1023 and 1", count[2*CW-1:CW], step[1]);
        end
        total++;
        if (count_s[2*CW-1:CW] !== 10'd0 || step_s[1] !== 1'b0) begin
            bad++;
            $display("FAIL sat_down: count=%0d step=%b want 0 and 0", count_s[2*CW-1:CW], step_s[1]);
        end
        tick(4);
        set_ab(1, 2'b11);
        tick(LAT);
        total++;
        if (count[2*CW-1:CW] !== 10'd0 || step[1] !== 1'b1 || count_s[2*CW-1:CW] !== 10'd1) begin
            bad++;
            $display("FAIL wrap_up: count=%0d step=%b sat=%0d want 0, 1, 1", count[2*CW-1:CW], step[1], count_s[2*CW-1:CW]);
        end
        tick(2);
    endtask

    task automatic test_error_clr();
        set_ab(0, 2'b11);
        tick(LAT);
        total++;
        if (err !== 2'b01 || count[CW-1:0] !== 10'd4 || step[0] !== 1'b0) begin
            bad++;
            $display("FAIL err_jump: err=%b count=%0d step=%b want 01, 4, 0", err, count[CW-1:0], step[0]);
        end
        tick(2);
        set_ab(0, 2'b01);
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        total++;
        if (count !== '0 || err !== '0 || step !== '0 || count_s !== '0 || err_s !== '0) begin
            bad++;
            $display("FAIL clr_priority: count=%h err=%b step=%b count_s=%h want zero", count, err, step, count_s);
        end
        tick(2);
        set_ab(0, 2'b00);
        tick(LAT);
        total++;
        if (count[CW-1:0] !== 10'd1 || step[0] !== 1'b1 || count_s[CW-1:0] !== 10'd1) begin
            bad++;
            $display("FAIL after_clr: count=%0d step=%b sat=%0d want 1, 1, 1", count[CW-1:0], step[0], count_s[CW-1:0]);
        end
        tick(2);
    endtask

    task automatic test_simultaneous();
        set_ab(0, 2'b10);
        set_ab(1, 2'b10);
        tick(LAT);
        total++;
        if (count !== {10'd1023, 10'd2} || step !== 2'b11) begin
            bad++;
            $display("FAIL simul_wrap: count=%h step=%b want %h, 11", count, step, {10'd1023, 10'd2});
        end
        total++;
        if (count_s !== {10'd0, 10'd2} || step_s !== 2'b01) begin
            bad++;
            $display("FAIL simul_sat: count=%h step=%b want %h, 01", count_s, step_s, {10'd0, 10'd2});
        end
        tick(2);
    endtask

    task automatic test_buttons();
        btn_n[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++;
            if (btn !== 3'b000) begin
                bad++;
                $display("FAIL btn_short: cycle %0d btn=%b want 000", i, btn);
            end
        end
        btn_n[0] = 1'b1;
        tick(6);
        total++;
        if (btn !== 3'b000) begin
            bad++;
            $display("FAIL btn_short_after: btn=%b want 000", btn);
        end
        btn_n[0] = 1'b0;
        tick(17);
        total++;
        if (btn !== 3'b000) begin
            bad++;
            $display("FAIL btn_early: btn=%b want 000 at 17 cycles", btn);
        end
        tick(1);
        total++;
        if (btn !== 3'b001 || btn_s !== 3'b001) begin
            bad++;
            $display("FAIL btn_accept: btn=%b btn_s=%b want 001 at 18 cycles", btn, btn_s);
        end
        btn_n[0] = 1'b1;
        tick(18);
        total++;
        if (btn !== 3'b000) begin
            bad++;
            $display("FAIL btn_release: btn=%b want 000", btn);
        end
    endtask

    task automatic test_reset_mid();
        int snap;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (count !== '0 || err !== '0 || count_s !== '0) begin
            bad++;
            $display("FAIL async_reset: count=%h err=%b count_s=%h want zero", count, err, count_s);
        end
        set_ab(0, 2'b11);
        tick(3);
        snap = steps_w0 + steps_w1 + steps_s0 + steps_s1;
        rst = 1'b1;
        tick(20);
        total++;
        if (count !== '0 || err !== '0 || steps_w0 + steps_w1 + steps_s0 + steps_s1 - snap != 0) begin
            bad++;
            $display("FAIL rearm: count=%h err=%b pulses=%0d want zero", count, err, steps_w0 + steps_w1 + steps_s0 + steps_s1 - snap);
        end
    endtask

`ifdef QUAD_GLITCH_FILTER_EN
    task automatic test_glitch();
        qa[0] = 1'b0;
        tick(1);
        qa[0] = 1'b1;
        tick(6);
        total++;
        if (count[CW-1:0] !== 10'd0 || err !== '0) begin
            bad++;
            $display("FAIL glitch_reject: count=%0d err=%b want 0, 00", count[CW-1:0], err);
        end
        set_ab(0, 2'b01);
        tick(3);
        total++;
        if (count[CW-1:0] !== 10'd0) begin
            bad++;
            $display("FAIL glitch_early: count=%0d want 0 at edge 3", count[CW-1:0]);
        end
        tick(1);
        total++;
        if (count[CW-1:0] !== 10'd1) begin
            bad++;
            $display("FAIL glitch_latency: count=%0d want 1 at edge 4", count[CW-1:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_error_clr();
        test_simultaneous();
        test_buttons();
        test_reset_mid();
`ifdef QUAD_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
